// File: rtl/writeback_stage.sv
// Registered, handshaked writeback stage: selects the rd source, waits for an
// out-of-order load response when needed, extends load data and counts retirements.
module writeback_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_rd_src,
    input  logic                         in_rd_we,
    input  logic [RADDR_W-1:0]           in_rd_addr,
    input  logic [XLEN-1:0]              in_alu_y,
    input  logic [XLEN-1:0]              in_pc_4,
    input  logic [XLEN-1:0]              in_csr_rdata,
    input  logic [1:0]                   in_dmem_width,
    input  logic                         in_dmem_zero_ext,
    input  logic [$clog2(XLEN/8)-1:0]    in_dmem_addr_lo,
    input  logic                         dmem_rvalid,
    input  logic [XLEN-1:0]              dmem_rdata,
    output logic                         rd_we,
    output logic [RADDR_W-1:0]           rd_addr,
    output logic [XLEN-1:0]              rd_wdata,
    output logic                         retire,
    output logic                         load_pending,
    output logic [CNT_W-1:0]             instret,
    output logic                         stray_rsp
);

    localparam int AW = $clog2(XLEN/8);

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_DMEM = 2'd1;
    localparam logic [1:0] SRC_PC4  = 2'd2;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state_q, state_d;
    logic                 rd_we_q, rd_we_d;
    logic [RADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]      rd_wdata_q, rd_wdata_d;
    logic                 retire_q, retire_d;
    logic [CNT_W-1:0]     instret_q, instret_d;
    logic                 stray_q, stray_d;

    // Load attributes captured at acceptance, consumed when the response arrives
    logic                 ld_we_q, ld_we_d;
    logic [RADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic [1:0]           ld_width_q, ld_width_d;
    logic                 ld_zext_q, ld_zext_d;
    logic [AW-1:0]        ld_lo_q, ld_lo_d;

    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0] data,
        input logic [1:0]      width,
        input logic            zext,
        input logic [AW-1:0]   lo
    );
        logic [1:0]         w;
        logic [AW-1:0]      off;
        logic [XLEN-1:0]    sh;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] w_s;
        w   = (XLEN == 32 && width == 2'd3) ? 2'd2 : width;
        off = lo;
        case (w)
            2'd1:    off[0]   = 1'b0;
            2'd2:    off[1:0] = 2'b00;
            2'd3:    off      = '0;
            default: ;
        endcase
        sh  = data >> {off, 3'b000};
        b_s = sh[7:0];
        h_s = sh[15:0];
        w_s = sh[31:0];
        case (w)
            2'd0:    load_extend = zext ? XLEN'(sh[7:0])  : XLEN'(b_s);
            2'd1:    load_extend = zext ? XLEN'(sh[15:0]) : XLEN'(h_s);
            2'd2:    load_extend = zext ? XLEN'(sh[31:0]) : XLEN'(w_s);
            default: load_extend = sh;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        rd_we_d    = 1'b0;
        retire_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_wdata_d = rd_wdata_q;
        ld_we_d    = ld_we_q;
        ld_addr_d  = ld_addr_q;
        ld_width_d = ld_width_q;
        ld_zext_d  = ld_zext_q;
        ld_lo_d    = ld_lo_q;
        stray_d    = stray_q | (dmem_rvalid & (state_q == IDLE));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_rd_src == SRC_DMEM) begin
                        ld_we_d    = in_rd_we;
                        ld_addr_d  = in_rd_addr;
                        ld_width_d = in_dmem_width;
                        ld_zext_d  = in_dmem_zero_ext;
                        ld_lo_d    = in_dmem_addr_lo;
                        state_d    = WAIT;
                    end else begin
                        case (in_rd_src)
                            SRC_ALU: rd_wdata_d = in_alu_y;
                            SRC_PC4: rd_wdata_d = in_pc_4;
                            default: rd_wdata_d = in_csr_rdata;
                        endcase
                        rd_we_d   = in_rd_we & (|in_rd_addr);
                        rd_addr_d = in_rd_addr;
                        retire_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    rd_wdata_d = load_extend(dmem_rdata, ld_width_q, ld_zext_q, ld_lo_q);
                    rd_we_d    = ld_we_q & (|ld_addr_q);
                    rd_addr_d  = ld_addr_q;
                    retire_d   = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Count moves together with the retire pulse it accounts for
        instret_d = instret_q + CNT_W'(retire_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_wdata_q <= '0;
            retire_q   <= 1'b0;
            instret_q  <= '0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_we_q    <= rd_we_d;
            rd_addr_q  <= rd_addr_d;
            rd_wdata_q <= rd_wdata_d;
            retire_q   <= retire_d;
            instret_q  <= instret_d;
            stray_q    <= stray_d;
        end
    end

    always_ff @(posedge clk) begin
        ld_we_q    <= ld_we_d;
        ld_addr_q  <= ld_addr_d;
        ld_width_q <= ld_width_d;
        ld_zext_q  <= ld_zext_d;
        ld_lo_q    <= ld_lo_d;
    end

    assign in_ready     = (state_q == IDLE);
    assign load_pending = (state_q == WAIT);
    assign rd_we        = rd_we_q;
    assign rd_addr      = rd_addr_q;
    assign rd_wdata     = rd_wdata_q;
    assign retire       = retire_q;
    assign instret      = instret_q;
    assign stray_rsp    = stray_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a 32-bit instance with a 4-bit counter
// and a 64-bit instance share one stimulus stream.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_rd_src;
    logic        in_rd_we;
    logic [4:0]  in_rd_addr;
    logic [63:0] in_alu_y, in_pc_4, in_csr_rdata, dmem_rdata;
    logic [1:0]  in_dmem_width;
    logic        in_dmem_zero_ext;
    logic [2:0]  in_dmem_addr_lo;
    logic        dmem_rvalid;

    logic        a_ready, a_we, a_retire, a_pending, a_stray;
    logic [4:0]  a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_instret;

    logic        b_ready, b_we, b_retire, b_pending, b_stray;
    logic [4:0]  b_addr;
    logic [63:0] b_wdata;
    logic [63:0] b_instret;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    writeback_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(4)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
        .in_rd_src(in_rd_src), .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr),
        .in_alu_y(in_alu_y[31:0]), .in_pc_4(in_pc_4[31:0]), .in_csr_rdata(in_csr_rdata[31:0]),
        .in_dmem_width(in_dmem_width), .in_dmem_zero_ext(in_dmem_zero_ext),
        .in_dmem_addr_lo(in_dmem_addr_lo[1:0]), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata[31:0]), .rd_we(a_we), .rd_addr(a_addr), .rd_wdata(a_wdata),
        .retire(a_retire), .load_pending(a_pending), .instret(a_instret), .stray_rsp(a_stray)
    );

    writeback_stage #(.XLEN(64), .RADDR_W(5), .CNT_W(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
        .in_rd_src(in_rd_src), .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr),
        .in_alu_y(in_alu_y), .in_pc_4(in_pc_4), .in_csr_rdata(in_csr_rdata),
        .in_dmem_width(in_dmem_width), .in_dmem_zero_ext(in_dmem_zero_ext),
        .in_dmem_addr_lo(in_dmem_addr_lo), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .rd_we(b_we), .rd_addr(b_addr), .rd_wdata(b_wdata),
        .retire(b_retire), .load_pending(b_pending), .instret(b_instret), .stray_rsp(b_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic        we;
        logic [4:0]  addr;
        logic [63:0] val;
        logic [1:0]  width;
        logic        zext;
        logic [2:0]  lo;
        int          lat;
        logic        exp_we;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction; for loads, hold off the response for v.lat cycles
    task automatic issue(input vec_t v);
        in_rd_src        = v.src;
        in_rd_we         = v.we;
        in_rd_addr       = v.addr;
        in_alu_y         = (v.src == 2'd0) ? v.val : 64'hBAD0_0000_0000_0A1A;
        in_pc_4          = (v.src == 2'd2) ? v.val : 64'hBAD0_0000_0000_0C04;
        in_csr_rdata     = (v.src == 2'd3) ? v.val : 64'hBAD0_0000_0000_0C5A;
        in_dmem_width    = v.width;
        in_dmem_zero_ext = v.zext;
        in_dmem_addr_lo  = v.lo;
        chk("in_ready_before_accept", {63'd0, a_ready}, 64'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (v.src == 2'd1) begin
            for (int c = 0; c < v.lat; c++) begin
                chk("wait_in_ready", {63'd0, a_ready}, 64'd0);
                chk("wait_load_pending", {63'd0, a_pending}, 64'd1);
                chk("wait_rd_we", {63'd0, a_we}, 64'd0);
                if (c == v.lat - 1) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = v.val;
                end
                step();
            end
            dmem_rvalid = 1'b0;
            dmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
        end
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        in_valid = 1'b0; in_rd_src = 2'd0; in_rd_we = 1'b0; in_rd_addr = 5'd0;
        in_alu_y = '0; in_pc_4 = '0; in_csr_rdata = '0; dmem_rdata = '0;
        in_dmem_width = 2'd0; in_dmem_zero_ext = 1'b0; in_dmem_addr_lo = 3'd0;
        dmem_rvalid = 1'b0;

        //           src   we    addr   val                        w     z     lo    lat exp_we exp_data
        vecs[0]  = '{2'd0, 1'b1, 5'd5,  64'h1234,                  2'd0, 1'b0, 3'd0, 0, 1'b1, 64'h0000_1234};
        vecs[1]  = '{2'd0, 1'b1, 5'd6,  64'hFFFF_0000,             2'd0, 1'b0, 3'd0, 0, 1'b1, 64'hFFFF_0000};
        vecs[2]  = '{2'd1, 1'b1, 5'd7,  64'h80AA_BBCC,             2'd0, 1'b0, 3'd3, 4, 1'b1, 64'hFFFF_FF80};
        vecs[3]  = '{2'd1, 1'b1, 5'd8,  64'h8001_0000,             2'd1, 1'b1, 3'd2, 1, 1'b1, 64'h0000_8001};
        vecs[4]  = '{2'd2, 1'b1, 5'd0,  64'h0000_0100,             2'd0, 1'b0, 3'd0, 0, 1'b0, 64'h0000_0100};
        vecs[5]  = '{2'd3, 1'b1, 5'd10, 64'hDEAD_BEEF,             2'd0, 1'b0, 3'd0, 0, 1'b1, 64'hDEAD_BEEF};
        vecs[6]  = '{2'd1, 1'b1, 5'd11, 64'hF00D_1234,             2'd1, 1'b0, 3'd3, 2, 1'b1, 64'hFFFF_F00D};
        vecs[7]  = '{2'd1, 1'b1, 5'd12, 64'h8765_4321,             2'd2, 1'b0, 3'd3, 1, 1'b1, 64'h8765_4321};
        vecs[8]  = '{2'd1, 1'b1, 5'd13, 64'h1234_5678,             2'd3, 1'b0, 3'd1, 3, 1'b1, 64'h1234_5678};
        vecs[9]  = '{2'd1, 1'b1, 5'd14, 64'h0000_AB00,             2'd0, 1'b1, 3'd1, 2, 1'b1, 64'h0000_00AB};
        vecs[10] = '{2'd0, 1'b0, 5'd7,  64'h0000_0055,             2'd0, 1'b0, 3'd0, 0, 1'b0, 64'h0000_0055};
        vecs[11] = '{2'd1, 1'b1, 5'd0,  64'h1234_567F,             2'd0, 1'b0, 3'd0, 1, 1'b0, 64'h0000_007F};

        #3;
        chk("rst_rd_we", {63'd0, a_we}, 64'd0);
        chk("rst_rd_addr", {59'd0, a_addr}, 64'd0);
        chk("rst_rd_wdata", {32'd0, a_wdata}, 64'd0);
        chk("rst_retire", {63'd0, a_retire}, 64'd0);
        chk("rst_instret", {60'd0, a_instret}, 64'd0);
        chk("rst_stray", {63'd0, a_stray}, 64'd0);
        chk("rst_in_ready", {63'd0, a_ready}, 64'd1);
        chk("rst_pending", {63'd0, a_pending}, 64'd0);
        chk("rst_instret64", b_instret, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i]);
            exp_cnt++;
            chk($sformatf("v%0d_rd_we", i), {63'd0, a_we}, {63'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_rd_addr", i), {59'd0, a_addr}, {59'd0, vecs[i].addr});
            chk($sformatf("v%0d_rd_wdata", i), {32'd0, a_wdata}, {32'd0, vecs[i].exp_data[31:0]});
            chk($sformatf("v%0d_retire", i), {63'd0, a_retire}, 64'd1);
            chk($sformatf("v%0d_instret", i), {60'd0, a_instret}, 64'(exp_cnt % 16));
            if (vecs[i].src == 2'd1) begin
                step();
                chk($sformatf("v%0d_rd_we_drop", i), {63'd0, a_we}, 64'd0);
                chk($sformatf("v%0d_retire_drop", i), {63'd0, a_retire}, 64'd0);
                chk($sformatf("v%0d_wdata_hold", i), {32'd0, a_wdata}, {32'd0, vecs[i].exp_data[31:0]});
            end
        end
        chk("no_stray_yet", {63'd0, a_stray}, 64'd0);

        // 64-bit datapath: double load passes through, word load sign-extends
        v = '{2'd1, 1'b1, 5'd3, 64'h8000_0000_0000_0001, 2'd3, 1'b0, 3'd5, 2, 1'b1, 64'h0};
        issue(v);
        exp_cnt++;
        chk("x64_double_wdata", b_wdata, 64'h8000_0000_0000_0001);
        chk("x64_double_we", {63'd0, b_we}, 64'd1);
        v = '{2'd1, 1'b1, 5'd4, 64'h8899_AABB_CCDD_EEFF, 2'd2, 1'b0, 3'd6, 1, 1'b1, 64'h0};
        issue(v);
        exp_cnt++;
        chk("x64_word_sext", b_wdata, 64'hFFFF_FFFF_8899_AABB);
        chk("x64_instret", b_instret, 64'd14);
        chk("x32_instret_after_x64", {60'd0, a_instret}, 64'(exp_cnt % 16));

        // Reset in the middle of a load: the late response is stray
        v = '{2'd1, 1'b1, 5'd9, 64'h0, 2'd2, 1'b0, 3'd0, 0, 1'b1, 64'h0};
        in_rd_src = v.src; in_rd_we = v.we; in_rd_addr = v.addr; in_dmem_width = v.width;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_pending", {63'd0, a_pending}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {63'd0, a_ready}, 64'd1);
        chk("mid_rst_instret", {60'd0, a_instret}, 64'd0);
        exp_cnt = 0;
        step();
        rst_n = 1'b1;
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'h0000_0000_5555_5555;
        step();
        dmem_rvalid = 1'b0;
        chk("stray_rd_we", {63'd0, a_we}, 64'd0);
        chk("stray_retire", {63'd0, a_retire}, 64'd0);
        chk("stray_wdata", {32'd0, a_wdata}, 64'd0);
        chk("stray_set", {63'd0, a_stray}, 64'd1);
        chk("stray_in_ready", {63'd0, a_ready}, 64'd1);
        chk("stray_set64", {63'd0, b_stray}, 64'd1);

        // Long ALU stream wraps the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            v = '{2'd0, 1'b1, 5'(i + 1), 64'(i * 3), 2'd0, 1'b0, 3'd0, 0, 1'b1, 64'(i * 3)};
            issue(v);
            exp_cnt++;
            if (i == 14) chk("cnt_all_ones", {60'd0, a_instret}, 64'hF);
        end
        chk("cnt_wrap", {60'd0, a_instret}, 64'd0);
        chk("cnt_last_wdata", {32'd0, a_wdata}, 64'd45);
        chk("cnt_last_addr", {59'd0, a_addr}, 64'd16);
        step();
        chk("idle_rd_we", {63'd0, a_we}, 64'd0);
        chk("idle_retire", {63'd0, a_retire}, 64'd0);
        chk("stray_sticky", {63'd0, a_stray}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered, handshaked writeback stage; successor to the combinational writeback mux.
- Takes one retiring instruction per handshake from the memory stage and waits for an out-of-order-latency data-memory load response when needed.
- Sign- or zero-extends load data for XLEN=32 or 64 and drives a registered register-file write port.
- Also counts retired instructions for the instret CSR.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
RADDR_W, 5, register index width
CNT_W, 64, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_rd_src  input  2  0=ALU_Y, 1=DMEM_RDATA, 2=PC_4, 3=CSR
in_rd_we  input  1  instruction writes rd
in_rd_addr  input  RADDR_W  destination register
in_alu_y  input  XLEN  ALU result
in_pc_4  input  XLEN  pc+4
in_csr_rdata  input  XLEN  CSR read data
in_dmem_width  input  2  0=byte, 1=half, 2=word, 3=double
in_dmem_zero_ext  input  1  1=zero-extend, 0=sign-extend
in_dmem_addr_lo  input  log2(XLEN/8)  byte offset within dmem word
dmem_rvalid  input  1  load response valid (single-cycle pulse)
dmem_rdata  input  XLEN  load response data
rd_we  output  1  register-file write enable (registered)
rd_addr  output  RADDR_W  register-file write index (registered)
rd_wdata  output  XLEN  register-file write data (registered)
retire  output  1  one-cycle pulse per completed instruction
load_pending  output  1  high while in WAIT
instret  output  CNT_W  count of retired instructions
stray_rsp  output  1  sticky: dmem_rvalid seen outside WAIT

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - rd_we=0, rd_addr=0, rd_wdata=0, retire=0, instret=0, stray_rsp=0.
  - Any pending load is discarded; its later response counts as stray.
- States: IDLE, WAIT.
  - in_ready = (state==IDLE), combinational.
  - load_pending = (state==WAIT).
- IDLE, accept (in_valid & in_ready):
  - Non-DMEM source: next cycle rd_wdata = the selected source; rd_we = in_rd_we & (in_rd_addr!=0); rd_addr = in_rd_addr; retire=1. State stays IDLE. Throughput is one instruction per cycle.
  - DMEM source: latch rd_we, rd_addr, width, zero_ext and addr_lo; go to WAIT. rd_we=0 and retire=0 next cycle.
- WAIT:
  - On dmem_rvalid: next cycle rd_wdata = decoded load, rd_we = latched enable & (addr!=0), retire=1; state to IDLE.
  - Earliest response is the cycle after acceptance. No upper bound on latency.
- Load decode:
  - Lane offset = addr_lo with its low bits cleared to the access size (byte: none, half: bit0, word: bits1:0, double: all).
  - Extract 8/16/32/64 bits at offset*8, then zero- or sign-extend to XLEN.
  - XLEN=32 with width=3 behaves as word.
- Outputs without an event:
  - rd_we and retire are 0 in every cycle not following a completion.
  - rd_addr and rd_wdata hold their last values.
- instret: increments by 1 in the cycle retire is 1; wraps modulo 2^CNT_W.
- dmem_rvalid in IDLE: ignored for writeback; sets stray_rsp, which is cleared only by reset.
- in_valid low in IDLE: no state change; outputs idle as above.
- rd_addr=0 writes: never asserted rd_we; the instruction still retires.

Test Plan:
1. Reset then back-to-back ALU ops (rd=5, alu_y=0x1234; rd=6, alu_y=0xFFFF0000) -> rd_we=1 on two consecutive cycles with those data, retire twice, instret=2, in_ready stays 1.
2. Signed byte load, XLEN=32, addr_lo=3, response arrives 4 cycles after acceptance with dmem_rdata=0x80AABBCC -> in_ready=0 and load_pending=1 during the wait; then rd_wdata=0xFFFFFF80, rd_we=1 for exactly one cycle.
3. Zero-extended half load, addr_lo=2, rdata=0x8001_0000 -> rd_wdata=0x00008001. With XLEN=64, double load of 0x8000000000000001 -> identical value.
4. Instruction with rd=0, rd_src=PC_4 -> rd_we=0, retire=1, instret increments.
5. Assert rst_n low during WAIT, release, then pulse dmem_rvalid -> no write, stray_rsp=1, in_ready=1.
6. Preload instret to all-ones via a long ALU stream with CNT_W=4 -> after 16 retirements instret=0.
